// File: rtl/apmu_counter_ctrl.sv
// Register front-end and sequencing for a bank of APMU event counters:
// event selection, enables, write strobes, sticky overflow/IRQ and a 64-bit read snapshot.
module apmu_counter_ctrl #(
    parameter int unsigned NumCounters  = 4,
    parameter int unsigned NumEvents    = 16,
    parameter int unsigned CounterWidth = 48
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumEvents-1:0]        event_i,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [5:0]                  addr_i,
    input  logic [31:0]                 wdata_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [31:0]                 rdata_o,
    output logic [NumCounters-1:0]      cnt_inc_o,
    output logic [NumCounters-1:0]      cnt_we_o,
    output logic [NumCounters-1:0]      cnth_we_o,
    output logic [31:0]                 cnt_wdata_o,
    input  logic [NumCounters-1:0][63:0] cnt_val_i,
    output logic                        irq_o
);

    localparam logic [1:0] GrpCfg  = 2'd0;
    localparam logic [1:0] GrpLo   = 2'd1;
    localparam logic [1:0] GrpHi   = 2'd2;
    localparam logic [1:0] GrpMisc = 2'd3;

    // Bus handshake: every request is granted in the same cycle (gnt = req);
    // exactly one rvalid follows one cycle later, for reads and writes alike.

    logic [1:0] grp;
    logic [3:0] idx;
    logic       idx_ok;
    logic       acc_wr;
    logic       acc_rd;

    assign grp    = addr_i[5:4];
    assign idx    = addr_i[3:0];
    assign idx_ok = ({1'b0, idx} < 5'(NumCounters));
    assign acc_wr = req_i & we_i;
    assign acc_rd = req_i & ~we_i;

    logic [NumCounters-1:0][4:0] sel_q;
    logic [NumCounters-1:0]      irq_en_q;
    logic [NumCounters-1:0]      en_q;
    logic                        inhibit_q;
    logic [NumCounters-1:0]      ovf_q;
    logic [NumEvents-1:0]        event_q;
    logic [31:0]                 shadow_q;
    logic [3:0]                  shadow_idx_q;
    logic                        shadow_vld_q;
    logic                        rvalid_q;
    logic [31:0]                 rdata_q;
    logic                        irq_q;

    logic [NumCounters-1:0]      cnt_inc;
    logic [NumCounters-1:0]      cnt_we;
    logic [NumCounters-1:0]      cnth_we;
    logic [NumCounters-1:0]      ovf_set;
    logic [NumCounters-1:0]      ovf_clr;
    logic [31:0]                 ev_ext;
    logic [31:0]                 rdata_d;
    logic [31:0]                 shadow_d;
    logic [3:0]                  shadow_idx_d;
    logic                        shadow_vld_d;

    // Zero-extend so an out-of-range SEL indexes a defined (zero) bit.
    assign ev_ext = 32'(event_q);

    always_comb begin
        cnt_inc = '0;
        cnt_we  = '0;
        cnth_we = '0;
        ovf_set = '0;
        for (int i = 0; i < NumCounters; i++) begin
            cnt_inc[i] = en_q[i] & ~inhibit_q &
                         ({1'b0, sel_q[i]} < 6'(NumEvents)) & ev_ext[sel_q[i]];
            cnt_we[i]  = acc_wr && (grp == GrpLo) && (idx == 4'(i));
            cnth_we[i] = acc_wr && (grp == GrpHi) && (idx == 4'(i));
            // A write strobe wins inside the counter, so that increment never wraps.
            ovf_set[i] = cnt_inc[i] & ~cnt_we[i] & ~cnth_we[i] &
                         (cnt_val_i[i][CounterWidth-1:0] == {CounterWidth{1'b1}});
        end
    end

    assign ovf_clr = (acc_wr && (addr_i == 6'h30)) ? wdata_i[NumCounters-1:0] : '0;

    always_comb begin
        rdata_d = '0;
        if (acc_rd) begin
            case (grp)
                GrpCfg: begin
                    for (int i = 0; i < NumCounters; i++) begin
                        if (idx == 4'(i)) rdata_d = {en_q[i], irq_en_q[i], 25'b0, sel_q[i]};
                    end
                end
                GrpLo: begin
                    for (int i = 0; i < NumCounters; i++) begin
                        if (idx == 4'(i)) rdata_d = cnt_val_i[i][31:0];
                    end
                end
                GrpHi: begin
                    for (int i = 0; i < NumCounters; i++) begin
                        if (idx == 4'(i)) begin
                            rdata_d = (shadow_vld_q && (shadow_idx_q == idx)) ?
                                      shadow_q : cnt_val_i[i][63:32];
                        end
                    end
                end
                GrpMisc: begin
                    if (idx == 4'h0)      rdata_d = 32'(ovf_q);
                    else if (idx == 4'h1) rdata_d = {31'b0, inhibit_q};
                end
                default: rdata_d = '0;
            endcase
        end
    end

    // The snapshot keeps the high word seen at the low read, so a LO/HI pair is coherent.
    always_comb begin
        shadow_d     = shadow_q;
        shadow_idx_d = shadow_idx_q;
        shadow_vld_d = shadow_vld_q;
        if (acc_rd && (grp == GrpLo) && idx_ok) begin
            for (int i = 0; i < NumCounters; i++) begin
                if (idx == 4'(i)) shadow_d = cnt_val_i[i][63:32];
            end
            shadow_idx_d = idx;
            shadow_vld_d = 1'b1;
        end
        if (acc_rd && (grp == GrpHi) && idx_ok && shadow_vld_q && (shadow_idx_q == idx)) begin
            shadow_vld_d = 1'b0;
        end
        if (acc_wr && ((grp == GrpLo) || (grp == GrpHi)) && idx_ok && (shadow_idx_q == idx)) begin
            shadow_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q        <= '0;
            irq_en_q     <= '0;
            en_q         <= '0;
            inhibit_q    <= 1'b0;
            ovf_q        <= '0;
            event_q      <= '0;
            shadow_q     <= '0;
            shadow_idx_q <= '0;
            shadow_vld_q <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            for (int i = 0; i < NumCounters; i++) begin
                if (acc_wr && (grp == GrpCfg) && (idx == 4'(i))) begin
                    sel_q[i]    <= wdata_i[4:0];
                    irq_en_q[i] <= wdata_i[30];
                    en_q[i]     <= wdata_i[31];
                end
            end
            if (acc_wr && (addr_i == 6'h31)) inhibit_q <= wdata_i[0];
            ovf_q        <= ovf_set | (ovf_q & ~ovf_clr);
            event_q      <= event_i;
            shadow_q     <= shadow_d;
            shadow_idx_q <= shadow_idx_d;
            shadow_vld_q <= shadow_vld_d;
            rvalid_q     <= req_i;
            rdata_q      <= rdata_d;
            irq_q        <= |(ovf_q & irq_en_q);
        end
    end

    assign gnt_o       = req_i;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign cnt_inc_o   = cnt_inc;
    assign cnt_we_o    = cnt_we;
    assign cnth_we_o   = cnth_we;
    assign cnt_wdata_o = wdata_i;
    assign irq_o       = irq_q;

endmodule
